// File: rtl/game_fsm_ctrl.sv
// Game-flow controller: MENU -> COUNTDOWN -> GAME -> SCORE, with debounced
// player buttons, game-duration selection and score / high-score tracking.
module game_fsm_ctrl #(
    parameter int CLK_HZ          = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CD_SECONDS      = 3,
    parameter int TIME_DEFAULT    = 30,
    parameter int TIME_MIN        = 10,
    parameter int TIME_MAX        = 120,
    parameter int TIME_STEP       = 10,
    parameter int SCORE_MAX       = 999
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       hit,
    input  logic       end_of_time,
    output logic [1:0] state_out,
    output logic [7:0] game_time,
    output logic [3:0] countdown,
    output logic [9:0] score,
    output logic [9:0] high_score,
    output logic       new_record
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PS_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    typedef enum logic [1:0] {
        S_MENU  = 2'b00,
        S_CD    = 2'b01,
        S_GAME  = 2'b10,
        S_SCORE = 2'b11
    } state_e;

    logic [2:0]      btn_raw_s;
    logic [2:0]      sync1_q, sync1_d, sync2_q, sync2_d;
    logic [2:0]      level_q, level_d, press_q, press_d;
    logic [DB_W-1:0] db_cnt_q [3];
    logic [DB_W-1:0] db_cnt_d [3];

    state_e          state_q, state_d;
    logic [7:0]      game_time_q, game_time_d;
    logic [3:0]      countdown_q, countdown_d;
    logic [PS_W-1:0] presc_q, presc_d;
    logic [9:0]      score_q, score_d, high_score_q, high_score_d;
    logic            new_record_q, new_record_d;
    logic            start_p_s, up_p_s, down_p_s;
    logic [9:0]      score_hit_s;
    logic [7:0]      time_up_s, time_down_s;

    assign btn_raw_s = {btn_down, btn_up, btn_start};
    assign start_p_s = press_q[0];
    assign up_p_s    = press_q[1];
    assign down_p_s  = press_q[2];

    // Button front end: synchronise, debounce, and emit a pulse on each accepted press.
    always_comb begin
        sync1_d = btn_raw_s;
        sync2_d = sync1_q;
        level_d = level_q;
        for (int i = 0; i < 3; i++) begin
            db_cnt_d[i] = {DB_W{1'b0}};
            if (sync2_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    level_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end else begin
                db_cnt_d[i] = {DB_W{1'b0}};
            end
        end
        press_d = level_d & ~level_q;
    end

    // Saturating helpers shared by the state transitions.
    always_comb begin
        if (hit && (score_q != 10'(SCORE_MAX))) begin
            score_hit_s = score_q + 10'd1;
        end else begin
            score_hit_s = score_q;
        end
        if ((9'(game_time_q) + 9'(TIME_STEP)) > 9'(TIME_MAX)) begin
            time_up_s = 8'(TIME_MAX);
        end else begin
            time_up_s = game_time_q + 8'(TIME_STEP);
        end
        if (9'(game_time_q) < (9'(TIME_MIN) + 9'(TIME_STEP))) begin
            time_down_s = 8'(TIME_MIN);
        end else begin
            time_down_s = game_time_q - 8'(TIME_STEP);
        end
    end

    // Game-flow next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        game_time_d  = game_time_q;
        countdown_d  = countdown_q;
        presc_d      = presc_q;
        score_d      = score_q;
        high_score_d = high_score_q;
        new_record_d = new_record_q;
        case (state_q)
            S_MENU: begin
                if (start_p_s) begin
                    state_d     = S_CD;
                    countdown_d = 4'(CD_SECONDS);
                    presc_d     = {PS_W{1'b0}};
                end else if (up_p_s && !down_p_s) begin
                    game_time_d = time_up_s;
                end else if (down_p_s && !up_p_s) begin
                    game_time_d = time_down_s;
                end else begin
                    game_time_d = game_time_q;
                end
            end
            S_CD: begin
                if (presc_q == PS_W'(CLK_HZ - 1)) begin
                    presc_d = {PS_W{1'b0}};
                    if (countdown_q <= 4'd1) begin
                        state_d      = S_GAME;
                        countdown_d  = 4'd0;
                        score_d      = 10'd0;
                        new_record_d = 1'b0;
                    end else begin
                        countdown_d = countdown_q - 4'd1;
                    end
                end else begin
                    presc_d = presc_q + PS_W'(1);
                end
            end
            S_GAME: begin
                score_d = score_hit_s;
                // The timer expiring wins over an abort arriving in the same cycle.
                if (end_of_time) begin
                    state_d = S_SCORE;
                    if (score_hit_s > high_score_q) begin
                        high_score_d = score_hit_s;
                        new_record_d = 1'b1;
                    end else begin
                        high_score_d = high_score_q;
                    end
                end else if (down_p_s) begin
                    state_d = S_MENU;
                end else begin
                    state_d = S_GAME;
                end
            end
            S_SCORE: begin
                if (start_p_s) begin
                    state_d      = S_MENU;
                    new_record_d = 1'b0;
                end else begin
                    state_d = S_SCORE;
                end
            end
            default: begin
                state_d = S_MENU;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 3'b000;
            sync2_q      <= 3'b000;
            level_q      <= 3'b000;
            press_q      <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= {DB_W{1'b0}};
            end
            state_q      <= S_MENU;
            game_time_q  <= 8'(TIME_DEFAULT);
            countdown_q  <= 4'd0;
            presc_q      <= {PS_W{1'b0}};
            score_q      <= 10'd0;
            high_score_q <= 10'd0;
            new_record_q <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            level_q      <= level_d;
            press_q      <= press_d;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            state_q      <= state_d;
            game_time_q  <= game_time_d;
            countdown_q  <= countdown_d;
            presc_q      <= presc_d;
            score_q      <= score_d;
            high_score_q <= high_score_d;
            new_record_q <= new_record_d;
        end
    end

    assign state_out  = state_q;
    assign game_time  = game_time_q;
    assign countdown  = countdown_q;
    assign score      = score_q;
    assign high_score = high_score_q;
    assign new_record = new_record_q;

endmodule

// File: tb/tb_game_fsm_ctrl.sv
// Randomised bench for game_fsm_ctrl against a behavioural model of the game flow.
module tb_game_fsm_ctrl;

    localparam int CLK_HZ = 10;
    localparam int DB     = 4;
    localparam int CD     = 3;
    localparam int T_DEF  = 30;
    localparam int T_MIN  = 10;
    localparam int T_MAX  = 120;
    localparam int T_STEP = 10;
    localparam int S_MAX  = 999;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_start = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic       hit = 1'b0, end_of_time = 1'b0;
    logic [1:0] state_out;
    logic [7:0] game_time;
    logic [3:0] countdown;
    logic [9:0] score, high_score;
    logic       new_record;
    logic [34:0] act_v;

    int vec_cnt = 0;
    int err_cnt = 0;
    int m_state, m_time, m_cd, m_score, m_high, m_rec;

    game_fsm_ctrl #(
        .CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DB), .CD_SECONDS(CD),
        .TIME_DEFAULT(T_DEF), .TIME_MIN(T_MIN), .TIME_MAX(T_MAX),
        .TIME_STEP(T_STEP), .SCORE_MAX(S_MAX)
    ) dut (
        .clk(clk), .rst(rst), .btn_start(btn_start), .btn_up(btn_up),
        .btn_down(btn_down), .hit(hit), .end_of_time(end_of_time),
        .state_out(state_out), .game_time(game_time), .countdown(countdown),
        .score(score), .high_score(high_score), .new_record(new_record)
    );

    always #5 clk = ~clk;

    assign act_v = {state_out, game_time, countdown, score, high_score, new_record};

    function automatic logic [34:0] exp_v();
        return {2'(m_state), 8'(m_time), 4'(m_cd), 10'(m_score), 10'(m_high), 1'(m_rec)};
    endfunction

    task automatic show_fail(input string nm);
        $display("FAIL %s: got st=%0d time=%0d cd=%0d score=%0d hi=%0d rec=%0d, want st=%0d time=%0d cd=%0d score=%0d hi=%0d rec=%0d",
                 nm, state_out, game_time, countdown, score, high_score, new_record,
                 m_state, m_time, m_cd, m_score, m_high, m_rec);
    endtask

    task automatic model_reset();
        m_state = 0; m_time = T_DEF; m_cd = 0; m_score = 0; m_high = 0; m_rec = 0;
    endtask

    task automatic model_press(input int idx);
        if (m_state == 0 && idx == 1) m_time = (m_time + T_STEP > T_MAX) ? T_MAX : m_time + T_STEP;
        else if (m_state == 0 && idx == 2) m_time = (m_time - T_STEP < T_MIN) ? T_MIN : m_time - T_STEP;
        else if (m_state == 2 && idx == 2) m_state = 0;
        else if (m_state == 3 && idx == 0) begin m_state = 0; m_rec = 0; end
    endtask

    task automatic model_hit();
        if (m_state == 2) m_score = (m_score + 1 > S_MAX) ? S_MAX : m_score + 1;
    endtask

    task automatic drive_btn(input int idx, input logic v);
        case (idx)
            0: btn_start = v;
            1: btn_up = v;
            default: btn_down = v;
        endcase
    endtask

    task automatic press_btn(input int idx);
        drive_btn(idx, 1'b1);
        repeat ($urandom_range(14, 10)) @(negedge clk);
        drive_btn(idx, 1'b0);
        repeat ($urandom_range(14, 10)) @(negedge clk);
        model_press(idx);
        vec_cnt++;
        if (act_v !== exp_v()) begin err_cnt++; show_fail($sformatf("press_btn%0d", idx)); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        vec_cnt++;
        if (act_v !== exp_v()) begin err_cnt++; show_fail("reset"); end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 4; i++) begin
            btn_up = 1'b1;
            repeat ($urandom_range(3, 1)) @(negedge clk);
            btn_up = 1'b0;
            repeat (8) @(negedge clk);
            vec_cnt++;
            if (act_v !== exp_v()) begin err_cnt++; show_fail("bounce"); end
        end
    endtask

    task automatic test_time_saturation();
        for (int i = 0; i < 12; i++) press_btn(1);
        vec_cnt++;
        if (game_time !== 8'(T_MAX)) begin err_cnt++; show_fail("time_max"); end
        for (int i = 0; i < 12; i++) press_btn(2);
        vec_cnt++;
        if (game_time !== 8'(T_MIN)) begin err_cnt++; show_fail("time_min"); end
    endtask

    task automatic test_up_down_same();
        btn_up = 1'b1; btn_down = 1'b1;
        repeat (12) @(negedge clk);
        btn_up = 1'b0; btn_down = 1'b0;
        repeat (12) @(negedge clk);
        vec_cnt++;
        if (act_v !== exp_v()) begin err_cnt++; show_fail("up_down_same"); end
    endtask

    task automatic test_random_menu();
        for (int i = 0; i < 10; i++) press_btn(($urandom_range(1, 0) == 0) ? 1 : 2);
    endtask

    task automatic test_ignored_pulses();
        end_of_time = 1'b1; hit = 1'b1;
        @(negedge clk);
        end_of_time = 1'b0; hit = 1'b0;
        repeat (2) @(negedge clk);
        vec_cnt++;
        if (act_v !== exp_v()) begin err_cnt++; show_fail("menu_ignores"); end
    endtask

    task automatic test_countdown(input bit with_up, input bit noise);
        bit entered = 1'b0;
        btn_start = 1'b1;
        if (with_up) btn_up = 1'b1;
        for (int w = 0; w < 40 && !entered; w++) begin
            @(negedge clk);
            if (state_out === 2'b01) entered = 1'b1;
        end
        if (!entered) begin
            vec_cnt++; err_cnt++;
            $display("FAIL countdown_entry: no COUNTDOWN within 40 cycles, state=%0d", state_out);
            btn_start = 1'b0; btn_up = 1'b0;
            return;
        end
        for (int k = 0; k <= CD * CLK_HZ; k++) begin
            if (k < CD * CLK_HZ) begin
                m_state = 1; m_cd = CD - k / CLK_HZ;
            end else begin
                m_state = 2; m_cd = 0; m_score = 0; m_rec = 0;
            end
            vec_cnt++;
            if (act_v !== exp_v()) begin err_cnt++; show_fail($sformatf("countdown_k%0d", k)); end
            if (k == 5) begin btn_start = 1'b0; btn_up = 1'b0; end
            if (noise && k == 12) begin end_of_time = 1'b1; hit = 1'b1; end
            if (k == 13) begin end_of_time = 1'b0; hit = 1'b0; end
            if (k < CD * CLK_HZ) @(negedge clk);
        end
    endtask

    task automatic test_hits(input int n);
        for (int i = 0; i < n; i++) begin
            hit = 1'b1;
            @(negedge clk);
            hit = 1'b0;
            model_hit();
            vec_cnt++;
            if (act_v !== exp_v()) begin err_cnt++; show_fail("hit"); end
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end
    endtask

    task automatic test_end_game(input bit with_hit);
        end_of_time = 1'b1; hit = with_hit;
        @(negedge clk);
        end_of_time = 1'b0; hit = 1'b0;
        if (with_hit) model_hit();
        m_state = 3;
        if (m_score > m_high) begin m_high = m_score; m_rec = 1; end
        vec_cnt++;
        if (act_v !== exp_v()) begin err_cnt++; show_fail("end_game"); end
        repeat (3) @(negedge clk);
        vec_cnt++;
        if (act_v !== exp_v()) begin err_cnt++; show_fail("score_hold"); end
    endtask

    task automatic test_first_game();
        test_countdown(1'b0, 1'b1);
        test_hits(5);
        test_end_game(1'b1);
        vec_cnt++;
        if ({score, high_score, new_record} !== {10'd6, 10'd6, 1'b1}) begin
            err_cnt++; show_fail("record_6");
        end
        press_btn(0);
    endtask

    task automatic test_second_game();
        test_countdown(1'b1, 1'b0);
        test_hits(4);
        test_end_game(1'b0);
        vec_cnt++;
        if ({score, high_score, new_record} !== {10'd4, 10'd6, 1'b0}) begin
            err_cnt++; show_fail("no_record_4");
        end
        press_btn(0);
    endtask

    task automatic test_abort();
        test_countdown(1'b0, 1'b0);
        test_hits($urandom_range(3, 1));
        press_btn(1);
        press_btn(0);
        press_btn(2);
        test_ignored_pulses();
    endtask

    task automatic test_reset_mid_game();
        test_countdown(1'b0, 1'b0);
        test_hits(7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        vec_cnt++;
        if (act_v !== exp_v()) begin err_cnt++; show_fail("reset_mid_game"); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_bounce();
        test_time_saturation();
        test_up_down_same();
        test_random_menu();
        test_ignored_pulses();
        test_first_game();
        test_second_game();
        test_abort();
        test_reset_mid_game();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/game_fsm_ctrl.md
Name: game_fsm_ctrl

Overview:
- Top-level game-flow controller. Sequences MENU -> COUNTDOWN -> GAME -> SCORE.
- Drives the 2-bit state bus and the selected game duration to the game timer, and consumes the timer's end_of_time pulse.
- Debounces the player buttons, keeps the current score and the high score, and flags a new record for the display logic.

Parameters:
- CLK_HZ, 100_000_000, clock cycles per second; sets the COUNTDOWN prescaler.
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable synchronised samples needed to accept a button level change.
- CD_SECONDS, 3, length of the pre-game countdown in seconds (1..15).
- TIME_DEFAULT, 30, game duration loaded at reset, in seconds.
- TIME_MIN, 10, lowest selectable duration.
- TIME_MAX, 120, highest selectable duration.
- TIME_STEP, 10, duration increment/decrement per button press.
- SCORE_MAX, 999, saturation value of the score.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- btn_start  in  1  raw, asynchronous button: start / acknowledge.
- btn_up  in  1  raw, asynchronous button: increase duration.
- btn_down  in  1  raw, asynchronous button: decrease duration; in GAME it aborts the game.
- hit  in  1  single-cycle pulse from game logic when a target is hit.
- end_of_time  in  1  single-cycle pulse from the game timer.
- state_out  out  2  00 MENU, 01 COUNTDOWN, 10 GAME, 11 SCORE.
- game_time  out  8  selected duration in seconds, sent to the timer.
- countdown  out  4  seconds left in COUNTDOWN; 0 in all other states.
- score  out  10  score of the current or last game.
- high_score  out  10  best score since reset.
- new_record  out  1  high in SCORE when the last game set a new high score.

Behaviour:
- All registers update on posedge clk. When rst is high, every output takes its reset value on that edge, regardless of state and including mid-game:
  - state_out = 00
  - game_time = TIME_DEFAULT
  - countdown = 0
  - score = 0
  - high_score = 0
  - new_record = 0
  - debounce/sync registers = 0
- Button front end (one per button):
  - 2-FF synchroniser.
  - Counter clears whenever the synchronised sample equals the debounced level.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the new value.
  - A 1-cycle press pulse fires on each rising edge of the debounced level. Release produces no pulse.
  - Pulses arriving in states that do not use them are dropped; they are never queued.
- MENU (00):
  - up pulse: game_time += TIME_STEP, clamped at TIME_MAX.
  - down pulse: game_time -= TIME_STEP, clamped at TIME_MIN.
  - If up and down pulse in the same cycle, game_time is unchanged.
  - start pulse: next state COUNTDOWN, countdown = CD_SECONDS, prescaler = 0. Start takes priority over up/down in the same cycle (game_time unchanged).
- COUNTDOWN (01):
  - Prescaler counts 0..CLK_HZ-1.
  - At the wrap, countdown decrements.
  - At the wrap where countdown == 1: next state GAME, countdown = 0, score = 0, new_record = 0.
  - hit and end_of_time are ignored.
- GAME (10):
  - hit: score + 1, saturating at SCORE_MAX.
  - end_of_time: next state SCORE. If the final score (including a hit in the same cycle) is strictly greater than high_score, then high_score = final score and new_record = 1.
  - down pulse: abort to MENU. score is kept; high_score and new_record are unchanged.
  - end_of_time beats an abort pulse in the same cycle.
  - up and start pulses are ignored.
  - state_out changes one cycle after the triggering input; end_of_time has 1-cycle latency to state_out = 11.
- SCORE (11):
  - Outputs hold.
  - start pulse: next state MENU, new_record = 0. score holds until the next game begins.
- game_time is frozen outside MENU.
- No illegal states exist; any decode fault returns the FSM to MENU.

Test Plan:
- Reset in GAME with score = 7 -> next edge: state 00, score 0, high_score 0, game_time 30.
- (DEBOUNCE_CYCLES=4) btn_up bounce shorter than 4 cycles -> no change. btn_up held steady, then pressed 12 times -> game_time 40, 50, … then saturates at 120. Then 12 btn_down presses -> saturates at 10.
- (CLK_HZ=10, CD_SECONDS=3) start in MENU -> countdown 3, 2, 1 with 10 cycles between steps; state becomes 10 exactly 30 cycles after entering 01, with score 0.
- In GAME: 5 hits, then end_of_time in the same cycle as a 6th hit -> state 11, score 6, high_score 6, new_record 1.
- Second game: 4 hits, then end_of_time -> score 4, high_score 6, new_record 0. Start -> state 00.
- In GAME, btn_down press -> state 00, high_score unchanged. end_of_time pulses in MENU and COUNTDOWN -> no effect.
